// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state encodings and default geometry for the load/store unit
package lsu_pkg;
  localparam int ANCHO_DEF = 32;
  localparam int LARGO_DEF = 1024;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;
endpackage

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake bundle between a requester and the load/store unit
interface lsu_if #(
  parameter int ANCHO = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [31:0]      req_addr;
  logic [ANCHO-1:0] req_wdata;
  logic             rsp_valid;
  logic [ANCHO-1:0] rsp_rdata;
  logic             rsp_err;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction for loads and lane merge for sub-word stores
module lsu_lane_align import lsu_pkg::*; #(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic [ANCHO-1:0] word_i,
  input  logic [1:0]       addr_i,
  input  size_e            size_i,
  input  logic             unsigned_i,
  input  logic [ANCHO-1:0] wdata_i,
  output logic [ANCHO-1:0] load_o,
  output logic [ANCHO-1:0] merged_o
);
  logic [4:0]       sh;
  logic [15:0]      lane;
  logic [ANCHO-1:0] mask;
  logic             sx;
  // shift the addressed lane down for loads and splice the store lane into the old word
  always_comb begin
    sh       = {addr_i, 3'b000};
    sx       = ~unsigned_i;
    lane     = 16'(word_i >> sh);
    mask     = (size_i == SZ_BYTE ? ANCHO'(8'hFF) : ANCHO'(16'hFFFF)) << sh;
    load_o   = size_i == SZ_BYTE ? {{(ANCHO-8){sx & lane[7]}}, lane[7:0]} :
               size_i == SZ_HALF ? {{(ANCHO-16){sx & lane[15]}}, lane} : word_i;
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and stores onto a synchronous single-port RAM
module load_store_unit import lsu_pkg::*; #(
  parameter int ANCHO = ANCHO_DEF,
  parameter int LARGO = LARGO_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  lsu_if.slave                     bus,
  output logic                     ram_write_enable,
  output logic                     ram_read_enable,
  output logic [$clog2(LARGO)-1:0] ram_addr,
  output logic [ANCHO-1:0]         ram_din,
  input  logic [ANCHO-1:0]         ram_dout
);
  localparam int AW = $clog2(LARGO);
  state_e           state_q, state_d;
  size_e            size_q, req_size;
  logic             we_q, uns_q, err_q, accept, req_err;
  logic [AW+1:0]    addr_q;
  logic [ANCHO-1:0] wdata_q, rdata_q, load_val, merged;
  assign req_size = size_e'(bus.req_size);
  assign req_err  = req_size == SZ_ILL || (req_size == SZ_HALF && bus.req_addr[0]) ||
                    (req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00) || bus.req_addr >= 32'(4 * LARGO);
  assign bus.req_ready    = state_q == IDLE && !RST;
  assign accept           = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid    = state_q == DONE;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign ram_read_enable  = state_q == RD && !RST;
  assign ram_write_enable = state_q == WR && !RST;
  assign ram_addr         = addr_q[AW+1:2];
  assign ram_din          = size_q == SZ_WORD ? wdata_q : merged;
  lsu_lane_align #(.ANCHO(ANCHO)) u_align (
    .word_i    (ram_dout),
    .addr_i    (addr_q[1:0]),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .wdata_i   (wdata_q),
    .load_o    (load_val),
    .merged_o  (merged)
  );
  // errors skip the RAM, word stores skip the read, everything else reads first
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? DONE : (bus.req_we && req_size == SZ_WORD) ? WR : RD;
      RD:      state_d = we_q ? WR : CAP;
      CAP, WR: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, latched request and response registers updated on entry to DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= req_size;
        addr_q  <= bus.req_addr[AW+1:0];
        wdata_q <= bus.req_wdata;
      end
      if (state_d == DONE) begin
        rdata_q <= state_q == CAP ? load_val : '0;
        err_q   <= state_q == IDLE;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors checked against a memory-level reference model
module tb_load_store_unit;
  typedef struct {int due; bit [31:0] rd; bit er;} exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ram_we, ram_re;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  bit   [31:0] ram_dout;
  bit   [31:0] ram [1024];
  bit   [31:0] mem [1024];
  exp_t        q[$];
  int          cyc = 0, last_due = -1, acc_cyc = 0, last_rsp_cyc = 0, total = 0, bad = 0;
  bit          go = 1'b0, rst_e, exp_v;
  bit   [31:0] hold_rd = 0, last_rd = 0;
  bit          hold_er = 0, last_er = 0;

  lsu_if #(.ANCHO(32)) bus ();
  load_store_unit #(.ANCHO(32), .LARGO(1024)) dut (
    .CLK(clk), .RST(rst), .bus(bus),
    .ram_write_enable(ram_we), .ram_read_enable(ram_re),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    if (ram_re) ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model(input bit we, input bit [1:0] sz, input bit un, input bit [31:0] a,
                                input bit [31:0] wd, output bit [31:0] rd, output bit er, output int lat);
    bit [31:0] w;
    int sh;
    er = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'd4096;
    rd = 0;
    lat = 1;
    if (!er) begin
      w = mem[a[11:2]];
      sh = 8 * int'(a[1:0]);
      if (we) begin
        lat = sz == 2'd2 ? 2 : 3;
        if (sz == 2'd0) w[sh +: 8] = wd[7:0];
        else if (sz == 2'd1) w[sh +: 16] = wd[15:0];
        else w = wd;
        mem[a[11:2]] = w;
      end else begin
        lat = 3;
        if (sz == 2'd0) begin
          rd = (w >> sh) & 32'hFF;
          if (!un && rd[7]) rd = rd | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          rd = (w >> sh) & 32'hFFFF;
          if (!un && rd[15]) rd = rd | 32'hFFFF_0000;
        end else rd = w;
      end
    end
  endfunction

  task automatic send(input bit we, input bit [1:0] sz, input bit un, input bit [31:0] a, input bit [31:0] wd);
    bit [31:0] rd;
    bit er;
    int lat, n = 0;
    while ((rst || cyc <= last_due) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 32'(cyc), 32'(last_due + 1));
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = un;
    bus.req_addr = a;
    bus.req_wdata = wd;
    model(we, sz, un, a, wd, rd, er, lat);
    acc_cyc = cyc;
    last_due = cyc + lat;
    q.push_back('{cyc + lat, rd, er});
    @(negedge clk);
  endtask

  task automatic wait_done(input bit [31:0] a);
    int n = 0;
    bus.req_valid = 1'b0;
    while (cyc <= last_due && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 32'(cyc), 32'(last_due + 1));
    if (a < 32'd4096) chk("ram_vs_model", ram[a[11:2]], mem[a[11:2]]);
  endtask

  task automatic op(input bit we, input bit [1:0] sz, input bit un, input bit [31:0] a, input bit [31:0] wd);
    send(we, sz, un, a, wd);
    wait_done(a);
  endtask

  always begin
    @(posedge clk);
    rst_e = rst;
    #1;
    if (go) begin
      if (rst_e) begin
        hold_rd = 0;
        hold_er = 0;
      end
      exp_v = q.size() > 0 && q[0].due == cyc;
      chk("rsp_valid", bus.rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_rdata", bus.rsp_rdata, q[0].rd);
        chk("rsp_err", bus.rsp_err, q[0].er);
        hold_rd = q[0].rd;
        hold_er = q[0].er;
        last_rd = bus.rsp_rdata;
        last_er = bus.rsp_err;
        last_rsp_cyc = cyc;
        void'(q.pop_front());
      end else begin
        chk("rdata_hold", bus.rsp_rdata, hold_rd);
        chk("err_hold", bus.rsp_err, hold_er);
      end
      chk("req_ready", bus.req_ready, !rst && cyc > last_due);
      chk("re_we_excl", ram_re & ram_we, 0);
      if (rst || cyc >= last_due) begin
        chk("re_quiet", ram_re, 0);
        chk("we_quiet", ram_we, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int a1;
    bit [1:0] esz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    bit       ewe [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit [31:0] ead [4] = '{32'h41, 32'h43, 32'h0, 32'h1000};
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_we", ram_we, 0);
    go = 1;
    rst = 0;
    send(1, 2, 0, 32'h34, 32'hDEADBEEF);
    a1 = acc_cyc;
    wait_done(32'h34);
    chk("st_word_lat", 32'(last_rsp_cyc - a1), 2);
    chk("ram13", ram[13], 32'hDEADBEEF);
    send(0, 2, 0, 32'h34, 0);
    a1 = acc_cyc;
    wait_done(32'h34);
    chk("ld_word_lat", 32'(last_rsp_cyc - a1), 3);
    chk("ld_word", last_rd, 32'hDEADBEEF);
    op(1, 2, 0, 32'h40, 32'h11223344);
    send(1, 0, 0, 32'h42, 32'h123456AA);
    a1 = acc_cyc;
    wait_done(32'h42);
    chk("st_byte_lat", 32'(last_rsp_cyc - a1), 3);
    chk("ram16_byte", ram[16], 32'h11AA3344);
    op(0, 0, 0, 32'h42, 0);
    chk("ld_byte_s", last_rd, 32'hFFFFFFAA);
    op(0, 0, 1, 32'h42, 0);
    chk("ld_byte_u", last_rd, 32'h000000AA);
    op(1, 2, 0, 32'h40, 32'h80010000);
    op(0, 1, 0, 32'h42, 0);
    chk("ld_half_s", last_rd, 32'hFFFF8001);
    op(0, 1, 1, 32'h42, 0);
    chk("ld_half_u", last_rd, 32'h00008001);
    for (int i = 0; i < 4; i++) begin
      send(ewe[i], esz[i], 0, ead[i], 32'hFFFF);
      a1 = acc_cyc;
      wait_done(ead[i]);
      chk("err_lat", 32'(last_rsp_cyc - a1), 1);
      chk("err_flag", last_er, 1);
      chk("err_rdata", last_rd, 0);
    end
    chk("ram16_untouched", ram[16], 32'h80010000);
    op(1, 1, 0, 32'h40, 32'h1234BEEF);
    chk("ram16_half", ram[16], 32'h8001BEEF);
    op(0, 0, 1, 32'h43, 0);
    chk("ld_b3_u", last_rd, 32'h00000080);
    op(0, 0, 0, 32'h41, 0);
    chk("ld_b1_s", last_rd, 32'hFFFFFFBE);
    send(0, 2, 0, 32'h34, 0);
    a1 = acc_cyc;
    send(0, 2, 0, 32'h40, 0);
    wait_done(32'h40);
    chk("b2b_gap", 32'(acc_cyc - a1), 4);
    chk("b2b_second", last_rd, 32'h8001BEEF);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2; bus.req_unsigned = 0;
    bus.req_addr = 32'h50; bus.req_wdata = 32'h12345678;
    last_due = cyc + 2;
    @(negedge clk);
    bus.req_valid = 0;
    chk("wr_active", ram_we, 1);
    rst = 1;
    last_due = cyc;
    #1;
    chk("wr_gated", ram_we, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_after_rst", bus.req_ready, 1);
    chk("ram20_kept", ram[20], 32'h0);
    @(negedge clk);
    rst = 1;
    bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2; bus.req_addr = 32'h34;
    repeat (3) @(negedge clk);
    rst = 0;
    send(0, 2, 0, 32'h34, 0);
    a1 = acc_cyc;
    wait_done(32'h34);
    chk("post_rst_lat", 32'(last_rsp_cyc - a1), 3);
    chk("post_rst_ld", last_rd, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
